// File: rtl/mod_exp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer and mon_prod:
// op codes, controller state encodings and the operand memory map.
package mod_exp_ctrl_pkg;

    localparam int unsigned DEF_EBITS    = 1024;
    // 11 bits so that mp_count can carry EBITS+1 without truncation
    localparam int unsigned DEF_IBITS    = 11;
    localparam int unsigned DEF_MP_COUNT = 1025;

    typedef enum logic [1:0] {
        OPXX = 2'd0,    // x_bar <- MonPro(x_bar, x_bar)
        OPXM = 2'd1,    // x_bar <- MonPro(x_bar, M_bar)
        OPX1 = 2'd2     // x_bar <- MonPro(x_bar, 1)
    } op_code_e;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SCAN      = 4'd1,
        ISSUE     = 4'd2,
        ACK       = 4'd3,
        WAIT      = 4'd4,
        DECIDE    = 4'd5,
        FIN_ISSUE = 4'd6,
        FIN_ACK   = 4'd7,
        FIN_WAIT  = 4'd8
    } state_e;

    localparam int unsigned XBAR_LO = 0;
    localparam int unsigned XBAR_HI = 1;
    localparam int unsigned MBAR_LO = 2;
    localparam int unsigned MBAR_HI = 3;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Handshake between the exponentiation sequencer (master) and mon_prod (slave).
interface mod_exp_ctrl_if
    import mod_exp_ctrl_pkg::*;
#(
    parameter int unsigned IBITS = DEF_IBITS
) ();

    logic             mp_start;
    op_code_e         mp_op_code;
    logic [IBITS-1:0] mp_count;
    logic             mp_stop;

    modport master (output mp_start, output mp_op_code, output mp_count, input mp_stop);
    modport slave  (input mp_start, input mp_op_code, input mp_count, output mp_stop);

endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right binary modular-exponentiation sequencer driving mon_prod.
// Optional feature macro: MODEXP_SKIP_LZ_EN (skip leading zero exponent bits in SCAN).
module mod_exp_ctrl
    import mod_exp_ctrl_pkg::*;
#(
    parameter int unsigned EBITS    = DEF_EBITS,
    parameter int unsigned IBITS    = DEF_IBITS,
    parameter int unsigned MP_COUNT = DEF_MP_COUNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [EBITS-1:0]  exponent,
    mod_exp_ctrl_if.master    mp,
    output logic              busy,
    output logic              done,
    output logic [IBITS-1:0]  bit_idx
);

    localparam int unsigned IDX_W = (EBITS > 1) ? $clog2(EBITS) : 1;

    state_e           state_q, state_d;
    logic [EBITS-1:0] e_q, e_d;
    logic [IBITS-1:0] idx_q, idx_d;
    op_code_e         op_q, op_d;
    logic             mp_start_q, mp_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cur_bit;

    assign cur_bit       = e_q[idx_q[IDX_W-1:0]];
    assign mp.mp_start   = mp_start_q;
    assign mp.mp_op_code = op_q;
    assign mp.mp_count   = IBITS'(MP_COUNT);
    assign busy          = busy_q;
    assign done          = done_q;
    assign bit_idx       = idx_q;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            e_q        <= '0;
            idx_q      <= IBITS'(EBITS - 1);
            op_q       <= OPXX;
            mp_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            e_q        <= e_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            mp_start_q <= mp_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        idx_d   = idx_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    e_d     = exponent;
                    idx_d   = IBITS'(EBITS - 1);
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
`ifdef MODEXP_SKIP_LZ_EN
                if (cur_bit) begin
                    op_d    = OPXX;
                    state_d = ISSUE;
                end else if (idx_q == '0) begin
                    op_d    = OPX1;
                    state_d = FIN_ISSUE;
                end else begin
                    idx_d   = idx_q - IBITS'(1);
                end
`else
                // a zero exponent needs only the final reduction
                if (e_q == '0) begin
                    op_d    = OPX1;
                    state_d = FIN_ISSUE;
                end else begin
                    op_d    = OPXX;
                    state_d = ISSUE;
                end
`endif
            end
            ISSUE:     state_d = ACK;
            ACK:       if (!mp.mp_stop) state_d = WAIT;
            WAIT:      if (mp.mp_stop)  state_d = DECIDE;
            DECIDE: begin
                if (op_q == OPXX && cur_bit) begin
                    op_d    = OPXM;
                    state_d = ISSUE;
                end else if (idx_q == '0) begin
                    op_d    = OPX1;
                    state_d = FIN_ISSUE;
                end else begin
                    idx_d   = idx_q - IBITS'(1);
                    op_d    = OPXX;
                    state_d = ISSUE;
                end
            end
            FIN_ISSUE: state_d = FIN_ACK;
            FIN_ACK:   if (!mp.mp_stop) state_d = FIN_WAIT;
            FIN_WAIT: begin
                if (mp.mp_stop) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase

        mp_start_d = (state_d == ISSUE) || (state_d == FIN_ISSUE);
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with behavioural mon_prod models (3-cycle op latency).
module tb_mod_exp_ctrl;
    import mod_exp_ctrl_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  exponent = '0;
    logic        busy, done;
    logic [9:0]  bit_idx;

    logic        start2 = 1'b0;
    logic [16:0] exponent2 = '0;
    logic        busy2, done2;
    logic [9:0]  bit_idx2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mod_exp_ctrl_if #(.IBITS(10)) mif ();
    mod_exp_ctrl_if #(.IBITS(10)) mif2 ();

    mod_exp_ctrl #(.EBITS(8), .IBITS(10), .MP_COUNT(9)) dut (
        .clk(clk), .reset(reset), .start(start), .exponent(exponent),
        .mp(mif), .busy(busy), .done(done), .bit_idx(bit_idx)
    );

    mod_exp_ctrl #(.EBITS(17), .IBITS(10), .MP_COUNT(18)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .exponent(exponent2),
        .mp(mif2), .busy(busy2), .done(done2), .bit_idx(bit_idx2)
    );

    // mon_prod timing model for dut (not reset by the controller reset)
    logic stop1 = 1'b1;
    int   cnt1  = 0;
    assign mif.mp_stop = stop1;
    always @(posedge clk) begin
        if (mif.mp_start) begin
            stop1 <= 1'b0;
            cnt1  <= LAT;
        end else if (!stop1) begin
            if (cnt1 == 1) stop1 <= 1'b1;
            else           cnt1  <= cnt1 - 1;
        end
    end

    // mon_prod arithmetic model for dut2: 16-bit modulus, R = 2^16, byte-wide memory
    longint unsigned m_mod = 1, r_inv = 1;
    logic [7:0]  mem [0:3];
    logic [15:0] x_init = '0, mbar_init = '0;
    logic        load2 = 1'b0;
    logic        stop2 = 1'b1;
    int          cnt2  = 0;
    logic [1:0]  op2   = '0;
    assign mif2.mp_stop = stop2;

    function automatic longint unsigned mont(input longint unsigned a, input longint unsigned b);
        return (((a * b) % m_mod) * r_inv) % m_mod;
    endfunction

    always @(posedge clk) begin
        longint unsigned xa, xb, r;
        if (load2) begin
            mem[XBAR_LO] <= x_init[7:0];
            mem[XBAR_HI] <= x_init[15:8];
            mem[MBAR_LO] <= mbar_init[7:0];
            mem[MBAR_HI] <= mbar_init[15:8];
        end else if (mif2.mp_start) begin
            stop2 <= 1'b0;
            cnt2  <= LAT;
            op2   <= mif2.mp_op_code;
        end else if (!stop2) begin
            if (cnt2 == 1) begin
                stop2 <= 1'b1;
                xa = longint'({mem[XBAR_HI], mem[XBAR_LO]});
                if (op2 == 2'd0)      xb = xa;
                else if (op2 == 2'd1) xb = longint'({mem[MBAR_HI], mem[MBAR_LO]});
                else                  xb = 1;
                r = mont(xa, xb);
                mem[XBAR_LO] <= r[7:0];
                mem[XBAR_HI] <= r[15:8];
            end else begin
                cnt2 <= cnt2 - 1;
            end
        end
    end

    function automatic byte op_char(input logic [1:0] c);
        case (c)
            2'd0:    return "S";
            2'd1:    return "M";
            2'd2:    return "F";
            default: return "?";
        endcase
    endfunction

    // Independent right-to-left reference for x^e mod m
    function automatic longint unsigned pow_mod(input longint unsigned b, input longint unsigned e,
                                                input longint unsigned m);
        longint unsigned acc = 1, base = b % m, ee = e;
        while (ee != 0) begin
            if (ee[0]) acc = (acc * base) % m;
            base = (base * base) % m;
            ee   = ee >> 1;
        end
        return acc;
    endfunction

    byte  ops_q[$];
    logic [1:0] cur_op;

    // Drives one run on dut and records what mon_prod saw; poke pulses start during WAIT
    task automatic run_dut(input logic [7:0] e, input bit poke, output int lat,
                           output logic [9:0] idx_end, output bit timed_out,
                           output bit busy_after, output int unstable);
        int low_cnt = 0;
        ops_q.delete();
        lat = -1; idx_end = '1; timed_out = 1'b1; busy_after = 1'b1; unstable = 0;
        cur_op = 2'd0;
        @(negedge clk);
        exponent = e;
        start    = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mif.mp_start) begin
                ops_q.push_back(op_char(mif.mp_op_code));
                cur_op = mif.mp_op_code;
                if (lat < 0) lat = cyc;
            end
            if (!mif.mp_stop) begin
                low_cnt++;
                if (mif.mp_op_code !== cur_op) unstable++;
                if (poke && low_cnt == 2) begin
                    start    = 1'b1;
                    exponent = 8'hFF;
                end
            end
            if (done) begin
                timed_out  = 1'b0;
                idx_end    = bit_idx;
                busy_after = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++;
        if (mif.mp_start !== 1'b0) begin n_fail++; $display("FAIL reset_mp_start got %b want 0", mif.mp_start); end
        n_checks++;
        if (mif.mp_op_code !== OPXX) begin n_fail++; $display("FAIL reset_op_code got %0d want 0", mif.mp_op_code); end
        n_checks++;
        if (bit_idx !== 10'd7) begin n_fail++; $display("FAIL reset_bit_idx got %0d want 7", bit_idx); end
        n_checks++;
        if (mif.mp_count !== 10'd9) begin n_fail++; $display("FAIL mp_count got %0d want 9", mif.mp_count); end
    endtask

    task automatic test_exp(input string name, input logic [7:0] e, input bit poke,
                            input string exp_ops, input int exp_lat, input logic [9:0] exp_idx);
        int lat, unstable, n;
        logic [9:0] idx_end;
        bit to, busy_after;
        run_dut(e, poke, lat, idx_end, to, busy_after, unstable);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL %s timeout waiting for done", name); end
        n_checks++;
        if (ops_q.size() != exp_ops.len()) begin
            n_fail++; $display("FAIL %s op_count got %0d want %0d", name, ops_q.size(), exp_ops.len());
        end
        n = (ops_q.size() < exp_ops.len()) ? ops_q.size() : exp_ops.len();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (ops_q[i] != exp_ops[i]) begin
                n_fail++; $display("FAIL %s op[%0d] got %c want %c", name, i, ops_q[i], exp_ops[i]);
            end
        end
        n_checks++;
        if (lat != exp_lat) begin n_fail++; $display("FAIL %s first_start_latency got %0d want %0d", name, lat, exp_lat); end
        n_checks++;
        if (idx_end !== exp_idx) begin n_fail++; $display("FAIL %s final_bit_idx got %0d want %0d", name, idx_end, exp_idx); end
        n_checks++;
        if (busy_after !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done got %b want 0", name, busy_after); end
        n_checks++;
        if (unstable != 0) begin n_fail++; $display("FAIL %s op_code_changes_mid_op got %0d want 0", name, unstable); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_width got %b want 0", name, done); end
    endtask

    task automatic test_e101();
`ifdef MODEXP_SKIP_LZ_EN
        test_exp("e101", 8'b101, 1'b0, "SMSSMF", 7, 10'd0);
`else
        test_exp("e101", 8'b101, 1'b0, "SSSSSSMSSMF", 2, 10'd0);
`endif
    endtask

    task automatic test_zero();
`ifdef MODEXP_SKIP_LZ_EN
        test_exp("e0", 8'h00, 1'b0, "F", 9, 10'd0);
`else
        test_exp("e0", 8'h00, 1'b0, "F", 2, 10'd7);
`endif
    endtask

    task automatic test_all_ones();
        test_exp("eFF", 8'hFF, 1'b0, "SMSMSMSMSMSMSMSMF", 2, 10'd0);
    endtask

    task automatic test_start_in_wait();
`ifdef MODEXP_SKIP_LZ_EN
        test_exp("start_in_wait", 8'b101, 1'b1, "SMSSMF", 7, 10'd0);
`else
        test_exp("start_in_wait", 8'b101, 1'b1, "SSSSSSMSSMF", 2, 10'd0);
`endif
    endtask

    task automatic test_reset_mid_op();
        bit seen = 1'b0;
        int extra = 0;
        @(negedge clk);
        exponent = 8'hFF;
        start    = 1'b1;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mif.mp_start) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL reset_mid_op no mp_start before reset"); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_op busy got %b want 0", busy); end
        n_checks++;
        if (mif.mp_start !== 1'b0) begin n_fail++; $display("FAIL reset_mid_op mp_start got %b want 0", mif.mp_start); end
        n_checks++;
        if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_mid_op state got %0d want 0", dut.state_q); end
        reset = 1'b0;
        seen  = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(negedge clk);
            if (mif.mp_start) extra++;
            if (mif.mp_stop) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL reset_mid_op timeout waiting for mp_stop"); end
        n_checks++;
        if (extra != 0) begin n_fail++; $display("FAIL reset_mid_op ops_after_reset got %0d want 0", extra); end
`ifdef MODEXP_SKIP_LZ_EN
        test_exp("after_reset", 8'b101, 1'b0, "SMSSMF", 7, 10'd0);
`else
        test_exp("after_reset", 8'b101, 1'b0, "SSSSSSMSSMF", 2, 10'd0);
`endif
    endtask

    task automatic test_real_path();
        longint unsigned x = 1234, r_mod, expv, got;
        int n_ops = 0;
        bit fin = 1'b0;
        m_mod = 61453;
        r_mod = 65536 % m_mod;
        for (longint unsigned i = 1; i < m_mod; i++) begin
            if ((r_mod * i) % m_mod == 1) begin r_inv = i; break; end
        end
        expv = pow_mod(x, 65537, m_mod);
        @(negedge clk);
        x_init    = 16'(r_mod);
        mbar_init = 16'((x * r_mod) % m_mod);
        load2     = 1'b1;
        @(negedge clk);
        load2     = 1'b0;
        exponent2 = 17'd65537;
        start2    = 1'b1;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (mif2.mp_start) n_ops++;
            if (done2) fin = 1'b1;
        end
        n_checks++;
        if (!fin) begin n_fail++; $display("FAIL real_path timeout waiting for done"); end
        n_checks++;
        if (n_ops != 20) begin n_fail++; $display("FAIL real_path op_count got %0d want 20", n_ops); end
        got = longint'({mem[XBAR_HI], mem[XBAR_LO]});
        n_checks++;
        if (got != expv) begin n_fail++; $display("FAIL real_path result got %0d want %0d", got, expv); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_e101();
        test_zero();
        test_all_ones();
        test_start_in_wait();
        test_reset_mid_op();
        test_real_path();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
